// File: rtl/tsens_seq_ctrl_if.sv
// Control/status bundle between the diode temperature sequencer and its front-end and consumer.
interface tsens_seq_ctrl_if #(
  parameter int N_CH  = 4,
  parameter int OUT_W = 8
);
  // One spare select bit so an out-of-range channel request reaches the sequencer and is flagged.
  localparam int CH_W = $clog2(N_CH) + 1;

  logic            en, start, cmp, ack;
  logic [CH_W-1:0] ch_sel;
  logic            pre_chrg, setup_bias, phi_dio, phi_big, cmp_p1, cmp_p2;
  logic            src_n, snk, busy, valid, err;
  logic [N_CH-1:0] ch_en;
  logic [OUT_W-1:0] code;

  modport master (
    output en, start, ch_sel, cmp, ack,
    input  pre_chrg, setup_bias, phi_dio, phi_big, cmp_p1, cmp_p2,
           src_n, snk, ch_en, busy, valid, code, err
  );
  modport slave (
    input  en, start, ch_sel, cmp, ack,
    output pre_chrg, setup_bias, phi_dio, phi_big, cmp_p1, cmp_p2,
           src_n, snk, ch_en, busy, valid, code, err
  );
endinterface

// File: rtl/tsens_seq_ctrl.sv
// Switched-cap diode temperature sequencer: precharge, bias setup loop, N_CONV conversion
// decisions, ones-count result with valid/ack handshake. All outputs registered.
module tsens_seq_ctrl #(
  parameter int N_CH      = 4,
  parameter int T_PRE     = 11,
  parameter int T_DIODE   = 4,
  parameter int T_BIG     = 8,
  parameter int N_SETUP   = 6,
  parameter int SETUP_MAX = 63,
  parameter int N_CONV    = 255,
  parameter int OUT_W     = 8
) (
  input logic             clk,
  input logic             reset,
  tsens_seq_ctrl_if.slave bus
);
  localparam int CH_W = $clog2(N_CH) + 1;
  localparam int TM1  = (T_PRE > T_DIODE + 1) ? T_PRE : T_DIODE + 1;
  localparam int TMX  = (TM1 > T_BIG + 1) ? TM1 : T_BIG + 1;
  localparam int CW   = $clog2(TMX + 1);
  localparam int DMX  = (SETUP_MAX > N_CONV) ? SETUP_MAX : N_CONV;
  localparam int DW   = $clog2(DMX + 1);
  localparam int SW   = $clog2(N_SETUP + 1);

  localparam logic [CH_W-1:0]  CH_LIM   = CH_W'(N_CH);
  localparam logic [CW-1:0]    PRE_LAST = CW'(T_PRE - 1);
  localparam logic [CW-1:0]    DIO_ON   = CW'(T_DIODE);
  localparam logic [CW-1:0]    BIG_ON   = CW'(T_BIG);
  localparam logic [CW-1:0]    BIG_DEC  = CW'(T_BIG - 1);
  localparam logic [SW-1:0]    SET_DONE = SW'(N_SETUP);
  localparam logic [DW-1:0]    SET_LIM  = DW'(SETUP_MAX);
  localparam logic [DW-1:0]    CONV_LIM = DW'(N_CONV);
  localparam logic [OUT_W-1:0] ONES_MAX = '1;

  typedef enum logic [2:0] {IDLE, PRE, S_DIO, S_BIG, C_DIO, C_BIG, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    setup_q, setup_d;
  logic [DW-1:0]    dec_q, dec_d;
  logic [OUT_W-1:0] ones_q, ones_d, code_q, code_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             err_q, err_d;
  logic             pre_q, pre_d, bias_q, bias_d, dio_q, dio_d, big_q, big_d;
  logic             p1_q, p1_d, p2_q, p2_d, srcn_q, srcn_d, snk_q, snk_d;
  logic             busy_q, busy_d, valid_q, valid_d;
  logic [N_CH-1:0]  chen_q, chen_d;
  logic             dec_now;

  // Phase states hold len+1 cycles: switch on for len, then one all-off gap cycle.
  // The decision is taken on the last phi_big-high cycle; its pulse lands in the gap.
  assign dec_now = (state_q == S_BIG || state_q == C_BIG) && cnt_q == BIG_DEC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;  cnt_q  <= '0;  setup_q <= '0;  dec_q <= '0;
      ones_q  <= '0;    code_q <= '0;  ch_q    <= '0;  err_q <= 1'b0;
      pre_q   <= 1'b0;  bias_q <= 1'b0; dio_q  <= 1'b0; big_q <= 1'b0;
      p1_q    <= 1'b0;  p2_q   <= 1'b1; srcn_q <= 1'b1; snk_q <= 1'b0;
      busy_q  <= 1'b0;  valid_q <= 1'b0; chen_q <= '0;
    end else begin
      state_q <= state_d; cnt_q  <= cnt_d;  setup_q <= setup_d; dec_q <= dec_d;
      ones_q  <= ones_d;  code_q <= code_d; ch_q    <= ch_d;    err_q <= err_d;
      pre_q   <= pre_d;   bias_q <= bias_d; dio_q  <= dio_d;    big_q <= big_d;
      p1_q    <= p1_d;    p2_q   <= p2_d;   srcn_q <= srcn_d;   snk_q <= snk_d;
      busy_q  <= busy_d;  valid_q <= valid_d; chen_q <= chen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    setup_d = setup_q;
    dec_d   = dec_q;
    ones_d  = ones_q;
    ch_d    = ch_q;
    code_d  = code_q;
    err_d   = err_q;
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          cnt_d = '0;
          if (bus.start) begin
            ch_d    = bus.ch_sel;
            setup_d = '0;
            dec_d   = '0;
            ones_d  = '0;
            if (bus.ch_sel >= CH_LIM) begin
              state_d = DONE;
              err_d   = 1'b1;
              code_d  = '0;
            end else begin
              state_d = PRE;
              err_d   = 1'b0;
            end
          end else if (state_q == DONE && bus.ack) begin
            state_d = IDLE;
          end
        end
        PRE: if (cnt_q == PRE_LAST) begin state_d = S_DIO; cnt_d = '0; end
        S_DIO: if (cnt_q == DIO_ON) begin state_d = S_BIG; cnt_d = '0; end
        C_DIO: if (cnt_q == DIO_ON) begin state_d = C_BIG; cnt_d = '0; end
        S_BIG: begin
          if (dec_now) begin
            dec_d = dec_q + 1'b1;
            if (!bus.cmp) setup_d = setup_q + 1'b1;
          end
          if (cnt_q == BIG_ON) begin
            cnt_d = '0;
            if (setup_q == SET_DONE) begin
              state_d = C_DIO;
              dec_d   = '0;
            end else if (dec_q == SET_LIM) begin
              state_d = DONE;
              err_d   = 1'b1;
              code_d  = '0;
            end else begin
              state_d = S_DIO;
            end
          end
        end
        C_BIG: begin
          if (dec_now) begin
            dec_d = dec_q + 1'b1;
            if (bus.cmp && ones_q != ONES_MAX) ones_d = ones_q + 1'b1;
          end
          if (cnt_q == BIG_ON) begin
            cnt_d = '0;
            if (dec_q == CONV_LIM) begin
              state_d = DONE;
              code_d  = ones_q;
            end else begin
              state_d = C_DIO;
            end
          end
        end
        default: begin state_d = IDLE; cnt_d = '0; end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    pre_d   = state_d == PRE;
    bias_d  = state_d == PRE || state_d == S_DIO || state_d == S_BIG;
    dio_d   = (state_d == S_DIO || state_d == C_DIO) && cnt_d < DIO_ON;
    big_d   = (state_d == S_BIG || state_d == C_BIG) && cnt_d < BIG_ON;
    busy_d  = !(state_d == IDLE || state_d == DONE);
    valid_d = state_d == DONE;
    chen_d  = busy_d ? (N_CH'(1) << ch_d) : '0;
    srcn_d  = !(bus.en && dec_now && bus.cmp);
    snk_d   = bus.en && dec_now && !bus.cmp;
    p1_d    = p1_q;
    if (!bus.en) p1_d = 1'b0;
    else if ((state_d == S_DIO || state_d == C_DIO) && cnt_d == '0) p1_d = !p1_q;
    p2_d    = !p1_d;
  end

  assign bus.pre_chrg   = pre_q;
  assign bus.setup_bias = bias_q;
  assign bus.phi_dio    = dio_q;
  assign bus.phi_big    = big_q;
  assign bus.cmp_p1     = p1_q;
  assign bus.cmp_p2     = p2_q;
  assign bus.src_n      = srcn_q;
  assign bus.snk        = snk_q;
  assign bus.ch_en      = chen_q;
  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.code       = code_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_tsens_seq_ctrl.sv
// Scoreboard bench for tsens_seq_ctrl: decision patterns drive cmp, a pattern-level model
// predicts each result, and a monitor checks phase timing and pops results on valid.
module tb_tsens_seq_ctrl;
  localparam int N_CH = 4, T_PRE = 11, T_DIODE = 4, T_BIG = 8;
  localparam int N_SETUP = 6, SETUP_MAX = 63, N_CONV = 255, OUT_W = 8;
  localparam int CH_W = $clog2(N_CH) + 1;

  typedef struct {
    int err, code, n_pre, n_sdec, n_src, n_snk, n_cdio;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0, failures = 0;
  exp_t sbq[$];
  bit   sp[SETUP_MAX];
  bit   cp[N_CONV];
  int   cur_ch = 0;
  bit   skip_len = 1'b0;
  int   ks = 0, kc = 0;

  tsens_seq_ctrl_if #(.N_CH(N_CH), .OUT_W(OUT_W)) bus ();

  tsens_seq_ctrl #(
    .N_CH(N_CH), .T_PRE(T_PRE), .T_DIODE(T_DIODE), .T_BIG(T_BIG), .N_SETUP(N_SETUP),
    .SETUP_MAX(SETUP_MAX), .N_CONV(N_CONV), .OUT_W(OUT_W)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // smode: 0 all snk, 1 all src, 2 random; cmode: 0 all ones, 1 alternating 1,0, 2 random
  task automatic fill(input int smode, input int cmode);
    for (int i = 0; i < SETUP_MAX; i++)
      sp[i] = (smode == 0) ? 1'b0 : (smode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
    for (int i = 0; i < N_CONV; i++)
      cp[i] = (cmode == 0) ? 1'b1 : (cmode == 1) ? (i % 2 == 0) : $urandom_range(0, 1) == 1;
  endtask

  function automatic exp_t model(input bit bad);
    exp_t e;
    int sn, n, ones;
    e = '{0, 0, 0, 0, 0, 0, 0};
    if (bad) begin
      e.err = 1;
      return e;
    end
    e.n_pre = T_PRE;
    sn = 0; n = 0;
    while (n < SETUP_MAX && sn < N_SETUP) begin
      if (!sp[n]) sn++;
      n++;
    end
    e.n_sdec = n;
    if (sn < N_SETUP) begin
      e.err = 1;
      return e;
    end
    ones = 0;
    foreach (cp[i]) ones += cp[i];
    e.code   = (ones > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : ones;
    e.n_src  = ones;
    e.n_snk  = N_CONV - ones;
    e.n_cdio = N_CONV;
    return e;
  endfunction

  task automatic start_run(input int ch, input bit push, input bit with_ack);
    if (push) sbq.push_back(model(ch >= N_CH));
    if (ch < N_CH) cur_ch = ch;
    bus.start = 1'b1; bus.ack = with_ack; bus.ch_sel = CH_W'(ch);
    tick();
    bus.start = 1'b0; bus.ack = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus.valid && n < 6000) begin tick(); n++; end
    chk({nm, "_valid"}, bus.valid, 1);
  endtask

  task automatic ack_it(input string nm);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk({nm, "_ack"}, {bus.valid, bus.busy}, 2'b00);
  endtask

  // cmp follows the current pattern; indices advance on every observed decision pulse
  initial begin
    logic pre_q = 1'b0;
    bus.cmp = 1'b0;
    forever begin
      tick();
      if (bus.pre_chrg && !pre_q) begin ks = 0; kc = 0; end
      pre_q = bus.pre_chrg;
      if (!bus.src_n || bus.snk) begin
        if (bus.setup_bias) ks++; else kc++;
      end
      bus.cmp = bus.setup_bias ? sp[(ks < SETUP_MAX) ? ks : 0] : cp[(kc < N_CONV) ? kc : 0];
    end
  end

  initial begin
    logic pp = 0, pd = 0, pb = 0, pv = 0, pbusy = 0, pp1 = 0, ppulse = 0, pulse;
    int   run_pre = 0, run_d = 0, run_b = 0, gap = 0;
    bit   seen = 0;
    int   n_pre = 0, n_sdec = 0, n_src = 0, n_snk = 0, n_cdio = 0;
    exp_t e;
    forever begin
      tick();
      if (reset) begin
        pp = 0; pd = 0; pb = 0; pv = 0; pbusy = 0; pp1 = 0; ppulse = 0;
        run_pre = 0; run_d = 0; run_b = 0; gap = 0; seen = 0;
        n_pre = 0; n_sdec = 0; n_src = 0; n_snk = 0; n_cdio = 0;
        continue;
      end
      chk("p2_inv", bus.cmp_p2, !bus.cmp_p1);
      chk("phi_overlap", bus.phi_dio && bus.phi_big, 0);
      chk("pulse_overlap", !bus.src_n && bus.snk, 0);
      chk("ch_en", bus.ch_en, bus.busy ? (1 << cur_ch) : 0);
      if (!skip_len) chk("p1_toggle", bus.cmp_p1 ^ pp1, bus.phi_dio && !pd);
      pulse = !bus.src_n || bus.snk;
      if (pulse) begin
        chk("pulse_pos", {ppulse, pb, bus.phi_big}, 3'b010);
        if (bus.setup_bias) n_sdec++;
        else if (!bus.src_n) n_src++;
        else n_snk++;
      end
      if (bus.pre_chrg) begin
        if (!pp) seen = 0;
        run_pre++; n_pre++;
      end else if (pp) begin
        if (!skip_len) chk("pre_len", run_pre, T_PRE);
        run_pre = 0;
      end
      if (bus.phi_dio) run_d++;
      else if (pd) begin
        if (!skip_len) chk("dio_len", run_d, T_DIODE);
        run_d = 0;
      end
      if (bus.phi_big) run_b++;
      else if (pb) begin
        if (!skip_len) chk("big_len", run_b, T_BIG);
        run_b = 0;
      end
      if (bus.phi_dio && !pd && !bus.setup_bias) n_cdio++;
      if (bus.phi_dio || bus.phi_big) begin
        if (((bus.phi_dio && !pd) || (bus.phi_big && !pb)) && seen && !skip_len)
          chk("gap", gap, 1);
        gap = 0; seen = 1;
      end else gap++;
      if (bus.valid && !pv) begin
        if (sbq.size() == 0) chk("unexpected_valid", sbq.size(), 1);
        else begin
          e = sbq.pop_front();
          chk("code", bus.code, e.code);
          chk("err", bus.err, e.err);
          chk("n_pre", n_pre, e.n_pre);
          chk("n_setup_dec", n_sdec, e.n_sdec);
          chk("n_src_conv", n_src, e.n_src);
          chk("n_snk_conv", n_snk, e.n_snk);
          chk("n_conv_dio", n_cdio, e.n_cdio);
        end
      end
      if ((bus.valid && !pv) || (!bus.busy && pbusy && !bus.valid)) begin
        n_pre = 0; n_sdec = 0; n_src = 0; n_snk = 0; n_cdio = 0;
      end
      pp = bus.pre_chrg; pd = bus.phi_dio; pb = bus.phi_big; pv = bus.valid;
      pbusy = bus.busy; pp1 = bus.cmp_p1; ppulse = pulse;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.en = 1'b0; bus.start = 1'b0; bus.ack = 1'b0; bus.ch_sel = '0;
    repeat (3) tick();
    chk("reset_ctl", {bus.pre_chrg, bus.setup_bias, bus.phi_dio, bus.phi_big, bus.cmp_p1,
        bus.cmp_p2, bus.src_n, bus.snk, bus.busy, bus.valid, bus.err}, 11'b00000110000);
    chk("reset_data", {bus.ch_en, bus.code}, 0);
    reset = 1'b0; bus.en = 1'b1;
    tick();
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("ack_idle_ignored", {bus.busy, bus.valid}, 2'b00);

    // all-ones conversion; a start while busy must be ignored
    fill(0, 0); start_run(0, 1, 0);
    repeat (40) tick();
    bus.start = 1'b1; bus.ch_sel = CH_W'(3); tick(); bus.start = 1'b0;
    chk("busy_start_ignored", {bus.busy, bus.valid}, 2'b10);
    wait_valid("t1"); ack_it("t1");

    // alternating decisions on channel 2
    fill(0, 1); start_run(2, 1, 0);
    wait_valid("t2");
    // start and ack together: start wins
    fill(2, 2); start_run(1, 1, 1);
    chk("restart", {bus.valid, bus.busy}, 2'b01);
    wait_valid("t2b"); ack_it("t2b");

    // setup never converges
    fill(1, 0); start_run(3, 1, 0);
    wait_valid("t3"); ack_it("t3");

    // bad channel goes straight to DONE
    start_run(5, 1, 0);
    chk("badch", {bus.valid, bus.err, bus.busy, bus.pre_chrg}, 4'b1100);
    ack_it("t5");

    // enable dropped in the middle of a conversion big-diode phase
    fill(0, 2); start_run(1, 0, 0);
    n = 0;
    while (!(kc >= 3 && bus.phi_big && !bus.setup_bias) && n < 3000) begin tick(); n++; end
    chk("abort_reach", n < 3000, 1);
    skip_len = 1'b1; bus.en = 1'b0;
    tick();
    chk("en_abort", {bus.pre_chrg, bus.setup_bias, bus.phi_dio, bus.phi_big, bus.src_n,
        bus.snk, bus.busy, bus.valid, bus.ch_en}, 13'b0000_1_000_0000);
    bus.en = 1'b1; tick(); skip_len = 1'b0;
    fill(2, 2); start_run($urandom_range(0, N_CH - 1), 1, 0);
    wait_valid("t4"); ack_it("t4");

    // asynchronous reset mid-run: no result may come out
    fill(0, 0); start_run(0, 0, 0);
    repeat (300) tick();
    skip_len = 1'b1;
    #2 reset = 1'b1;
    #1 chk("async_reset", {bus.pre_chrg, bus.setup_bias, bus.phi_dio, bus.phi_big, bus.cmp_p1,
        bus.cmp_p2, bus.src_n, bus.snk, bus.busy, bus.valid, bus.err, bus.ch_en, bus.code},
        {11'b00000110000, 12'b0});
    tick(); reset = 1'b0; tick(); skip_len = 1'b0;

    for (int i = 0; i < 3; i++) begin
      fill(2, 2); start_run($urandom_range(0, N_CH), 1, 0);
      wait_valid("rnd"); ack_it("rnd");
    end
    repeat (5) tick();
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
